delay_scheduler: RTL and testbench

- Multi-channel microsecond delay scheduler for the blackjack controller.
- Owns a 1 µs timebase and gives `NUM_CH` requesters independent one-shot delays, such as dealer card pacing, LED blink and result display hold.
- Reports expirations one at a time to the game FSM through a valid/ready event port, using round-robin arbitration.

---
 rtl/delay_sched_pkg.sv | 35 +++
 rtl/us_tick_gen.sv | 40 ++++
 rtl/delay_scheduler.sv | 114 +++++++++++
 tb/tb_delay_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the multi-channel microsecond delay scheduler.
// Optional feature macro used by this slice: DELAY_SCHED_PAUSE_EN (adds a pause input).
package delay_sched_pkg;

  // Per-channel lifecycle: counting down, or expired and waiting to be reported.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } ch_state_t;

  localparam int DEF_CLK_PER_US = 50;
  localparam int DEF_DLY_W      = 24;
  localparam int DEF_NUM_CH     = 4;
  localparam int MAX_CH         = 8;

  // Round-robin search: first set bit of req starting at last+1 (mod n).
  // Scans from the farthest candidate to the nearest so the nearest wins.
  // Returns 0 when req is empty; callers gate on |req.
  function automatic int rr_next(input logic [MAX_CH-1:0] req,
                                 input int                last,
                                 input int                n);
    int         res;
    int         idx;
    logic [2:0] sel;
    res = 0;
    for (int k = n; k >= 1; k--) begin
      idx = (last + k) % n;
      sel = 3'(idx);
      if (req[sel]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks.
// With DELAY_SCHED_PAUSE_EN defined, pause holds the count and masks the tick.
module us_tick_gen
  import delay_sched_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US
) (
  input  logic clk,
  input  logic rst,
`ifdef DELAY_SCHED_PAUSE_EN
  input  logic pause,
`endif
  output logic tick_us
);

  localparam int                CNT_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_PER_US - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_run;

`ifdef DELAY_SCHED_PAUSE_EN
  assign w_run = ~pause;
`else
  assign w_run = 1'b1;
`endif

  // Tick is decoded from the count so the period is exactly CLK_PER_US cycles.
  assign tick_us = w_run && (r_cnt == LAST);

  // Free-running 0..CLK_PER_US-1 counter, frozen while paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// Multi-channel one-shot microsecond delay scheduler with a round-robin
// valid/ready expiration event port.
// Optional feature macro: DELAY_SCHED_PAUSE_EN (pause input freezes the timebase).
//
// Event port handshake: evt_valid/evt_ch are registered and held unchanged
// while evt_valid=1 and evt_ready=0; a transfer happens in any cycle where
// evt_valid & evt_ready, and the next grant may appear the following cycle.
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter  int CLK_PER_US = DEF_CLK_PER_US,
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int DLY_W      = DEF_DLY_W,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*DLY_W-1:0] delay_us,
  output logic [NUM_CH-1:0]       busy,
  output logic                    evt_valid,
  output logic [CH_W-1:0]         evt_ch,
  input  logic                    evt_ready,
`ifdef DELAY_SCHED_PAUSE_EN
  input  logic                    pause,
`endif
  output logic                    tick_us
);

  logic              w_tick;
  logic              w_xfer;
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_clr;
  logic [MAX_CH-1:0] w_req;
  logic [CH_W-1:0]   w_pick;
  logic              r_gnt_valid;
  logic [CH_W-1:0]   r_gnt_ch;
  logic [CH_W-1:0]   r_last;

  us_tick_gen #(
    .CLK_PER_US (CLK_PER_US)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
`ifdef DELAY_SCHED_PAUSE_EN
    .pause   (pause),
`endif
    .tick_us (w_tick)
  );

  assign tick_us   = w_tick;
  assign w_xfer    = r_gnt_valid & evt_ready;
  assign evt_valid = r_gnt_valid;
  assign evt_ch    = r_gnt_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t        r_state;
    logic [DLY_W-1:0] r_cnt;
    logic [DLY_W-1:0] w_dly;

    assign w_dly     = delay_us[i*DLY_W +: DLY_W];
    assign w_clr[i]  = w_xfer && (r_gnt_ch == CH_W'(i));
    assign w_pend[i] = (r_state == PEND);
    assign busy[i]   = (r_state != IDLE);

    // Channel FSM: start (re)loads, ticks count down, transfer retires PEND.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE, RUN: begin
            if (start[i]) begin
              r_cnt   <= w_dly;
              r_state <= (w_dly == '0) ? PEND : RUN;
            end else if (r_state == RUN && w_tick) begin
              if (r_cnt == DLY_W'(1)) r_state <= PEND;
              else                    r_cnt   <= r_cnt - 1'b1;
            end
          end
          PEND: begin
            if (w_clr[i]) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Candidates for the next grant; the channel retiring this cycle is excluded
  // so back-to-back grants never re-present it.
  always_comb begin
    w_req                = '0;
    w_req[NUM_CH-1:0]    = w_pend & ~w_clr;
    w_pick               = CH_W'(rr_next(w_req,
                                         w_xfer ? int'(r_gnt_ch) : int'(r_last),
                                         NUM_CH));
  end

  // Grant register: hold while stalled, otherwise (re)grant round-robin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_valid <= 1'b0;
      r_gnt_ch    <= '0;
      r_last      <= CH_W'(NUM_CH - 1);
    end else if (!r_gnt_valid || evt_ready) begin
      if (w_xfer) r_last <= r_gnt_ch;
      r_gnt_valid <= |w_req;
      if (|w_req) r_gnt_ch <= w_pick;
    end
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Self-checking bench for delay_scheduler (CLK_PER_US=4, NUM_CH=4).
// Pause scenarios are included when DELAY_SCHED_PAUSE_EN is defined.
module tb_delay_scheduler;

  localparam int CPU = 4;
  localparam int NCH = 4;
  localparam int DW  = 8;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PEND = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    start = '0;
  logic [NCH*DW-1:0] delay_us = '0;
  logic [NCH-1:0]    busy;
  logic              evt_valid;
  logic [1:0]        evt_ch;
  logic              evt_ready = 1'b0;
  logic              tick_us;
  logic              pause = 1'b0;
  logic              pause_eff;

`ifdef DELAY_SCHED_PAUSE_EN
  assign pause_eff = pause;
`else
  assign pause_eff = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  delay_scheduler #(
    .CLK_PER_US (CPU),
    .NUM_CH     (NCH),
    .DLY_W      (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .delay_us  (delay_us),
    .busy      (busy),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready),
`ifdef DELAY_SCHED_PAUSE_EN
    .pause     (pause),
`endif
    .tick_us   (tick_us)
  );

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  int         obs_q[$];
  logic [1:0] exp_q[$];
  int         tick_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is tracked as an absolute tick count; a channel expires when the
  // global tick count reaches its deadline.
  int m_pre;
  int m_ticks;
  int m_st[NCH];
  int m_dead[NCH];
  bit m_gv;
  int m_gch;
  int m_last;

  task automatic model_reset();
    m_pre   = 0;
    m_ticks = 0;
    for (int i = 0; i < NCH; i++) begin
      m_st[i]   = M_IDLE;
      m_dead[i] = 0;
    end
    m_gv   = 1'b0;
    m_gch  = 0;
    m_last = NCH - 1;
  endtask

  // One clock: compare at negedge, advance model, drive next inputs after edge.
  task automatic cycle();
    bit             tk;
    bit             xfer;
    bit             found;
    int             nst[NCH];
    int             base;
    int             c;
    int             d;
    logic [NCH-1:0] exp_busy;
    @(negedge clk);
    tk = (m_pre == CPU - 1) && !pause_eff;
    for (int i = 0; i < NCH; i++) exp_busy[i] = (m_st[i] != M_IDLE);
    check("tick_us", tick_us, tk);
    check("busy", busy, exp_busy);
    check("evt_valid", evt_valid, m_gv);
    if (m_gv) check("evt_ch", evt_ch, m_gch);
    if (tick_us) tick_seen++;
    if (evt_valid && evt_ready) obs_q.push_back(int'(evt_ch));
    if (rst) begin
      model_reset();
    end else begin
      xfer = m_gv && evt_ready;
      for (int i = 0; i < NCH; i++) begin
        nst[i] = m_st[i];
        if (m_st[i] == M_PEND) begin
          if (xfer && m_gch == i) nst[i] = M_IDLE;
        end else if (start[i]) begin
          d = int'(delay_us[i*DW +: DW]);
          if (d == 0) nst[i] = M_PEND;
          else begin
            nst[i]    = M_RUN;
            m_dead[i] = m_ticks + int'(tk) + d;
          end
        end else if (m_st[i] == M_RUN && tk && (m_ticks + 1 == m_dead[i])) begin
          nst[i] = M_PEND;
        end
      end
      if (!m_gv || evt_ready) begin
        base = xfer ? m_gch : m_last;
        if (xfer) m_last = m_gch;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
          c = (base + k) % NCH;
          if (!found && m_st[c] == M_PEND && !(xfer && c == m_gch)) begin
            found = 1'b1;
            m_gch = c;
          end
        end
        m_gv = found;
      end
      for (int i = 0; i < NCH; i++) m_st[i] = nst[i];
      m_ticks += int'(tk);
      if (!pause_eff) m_pre = (m_pre + 1) % CPU;
    end
    @(posedge clk);
    #1;
    start = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic kick(input int ch, input int dly);
    delay_us[ch*DW +: DW] = DW'(dly);
    start[ch]             = 1'b1;
  endtask

  task automatic wait_event(input int budget);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      cycle();
      n++;
    end
    check("event_within_budget", obs_q.size() != 0, 1);
  endtask

`ifdef DELAY_SCHED_PAUSE_EN
  // Align to a tick, start ch0 with delay 4, optionally pause mid-count, and
  // return the cycles from start to transfer.
  task automatic pause_case(input int pcyc, output int lat);
    int n;
    evt_ready = 1'b1;
    n = 0;
    while (!tick_us && n < 10) begin cycle(); n++; end
    cycle();
    obs_q.delete();
    kick(0, 4);
    cycle();
    lat = 1;
    repeat (5) begin cycle(); lat++; end
    pause = (pcyc > 0);
    repeat (pcyc) begin cycle(); lat++; end
    pause = 1'b0;
    while (obs_q.size() == 0 && lat < 200) begin cycle(); lat++; end
    check("pause_event_seen", obs_q.size(), 1);
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    int lat0;
    int lat1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_evt_valid", evt_valid, 0);
    check("reset_evt_ch", evt_ch, 0);
    check("reset_tick", tick_us, 0);

    // Timebase: ticks at cycles 4, 8, 12, 16, 20 after reset release.
    tick_seen = 0;
    repeat (20) cycle();
    check("tick_count_20", tick_seen, 5);

    // Single delay on ch0.
    evt_ready = 1'b1;
    obs_q.delete();
    kick(0, 3);
    cycle();
    check("single_busy_rise", busy[0], 1);
    repeat (20) cycle();
    check("single_event_count", obs_q.size(), 1);
    if (obs_q.size() > 0) check("single_event_ch", obs_q[0], 0);
    check("single_busy_fall", busy[0], 0);

    // Round robin with stalled consumer.
    evt_ready = 1'b0;
    obs_q.delete();
    kick(1, 2); kick(2, 2); kick(3, 2);
    cycle();
    repeat (30) cycle();
    check("rr_hold_valid", evt_valid, 1);
    check("rr_hold_ch", evt_ch, 1);
    evt_ready = 1'b1;
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    repeat (10) cycle();
    check("rr_event_count", obs_q.size(), 3);
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check("rr_order", obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();

    // Zero delay: evt_valid two cycles after start.
    obs_q.delete();
    kick(2, 0);
    cycle();
    check("zero_busy", busy[2], 1);
    check("zero_valid_early", evt_valid, 0);
    cycle();
    check("zero_valid_at2", evt_valid, 1);
    check("zero_ch_at2", evt_ch, 2);
    repeat (4) cycle();

    // Restart: delay 5, restart with 2 after 3 ticks.
    obs_q.delete();
    kick(0, 5);
    cycle();
    tick_seen = 0;
    for (int n = 0; n < 40 && tick_seen < 3; n++) cycle();
    kick(0, 2);
    cycle();
    tick_seen = 0;
    wait_event(60);
    check("restart_ticks", tick_seen, 2);
    if (obs_q.size() > 0) check("restart_ch", obs_q[0], 0);
    repeat (4) cycle();

    // Start ignored in PEND and during own transfer cycle.
    evt_ready = 1'b0;
    obs_q.delete();
    kick(3, 1);
    cycle();
    repeat (8) cycle();
    check("pend_busy", busy[3], 1);
    kick(3, 3);
    cycle();
    kick(3, 3);
    evt_ready = 1'b1;
    repeat (30) cycle();
    check("pend_one_event", obs_q.size(), 1);
    if (obs_q.size() > 0) check("pend_event_ch", obs_q[0], 3);

    // Reset mid-run discards everything.
    obs_q.delete();
    kick(1, 10);
    cycle();
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", evt_valid, 0);
    repeat (60) cycle();
    check("midrst_no_event", obs_q.size(), 0);

`ifdef DELAY_SCHED_PAUSE_EN
    pause_case(0, lat0);
    repeat (4) cycle();
    pause_case(40, lat1);
    check("pause_extra_latency", lat1 - lat0, 40);
    repeat (4) cycle();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 7) == 0) kick(ch, $urandom_range(0, 6));
      evt_ready = ($urandom_range(0, 3) != 0);
`ifdef DELAY_SCHED_PAUSE_EN
      pause = ($urandom_range(0, 9) == 0);
`endif
      rst = ($urandom_range(0, 249) == 0);
      cycle();
    end
    rst       = 1'b0;
    pause     = 1'b0;
    evt_ready = 1'b1;
    repeat (60) cycle();
    check("drain_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
